// File: rtl/clip_pkg.sv
// Shared definitions for the clip playback scheduler.
// Holds the FSM state encoding, clip count, the ROM start/end address tables
// and the arbiter grant payload.
package clip_pkg;

  localparam int unsigned NUM_CLIPS = 3;
  localparam int unsigned IDX_W     = 2;

  // cur_clip value reported while nothing is playing
  localparam logic [IDX_W-1:0] IDLE_IDX = 2'd3;

  // Cycles from a PACE exit edge to the following write edge (PACE, ADDR, WAIT, PUSH)
  localparam int unsigned PIPE_LAT = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    PUSH,
    PACE
  } state_t;

  // Inclusive ROM address range of each clip
  localparam int unsigned CLIP_START [NUM_CLIPS] = '{0, 27101, 43831};
  localparam int unsigned CLIP_END   [NUM_CLIPS] = '{27100, 43830, 54300};

  // Arbiter result: request seen, index of the winner and its one-hot mask
  typedef struct packed {
    logic                 valid;
    logic [IDX_W-1:0]     idx;
    logic [NUM_CLIPS-1:0] onehot;
  } grant_t;

  function automatic int unsigned clip_start(input logic [IDX_W-1:0] idx);
    clip_start = (32'(idx) < NUM_CLIPS) ? CLIP_START[idx] : 32'd0;
  endfunction

  function automatic int unsigned clip_end(input logic [IDX_W-1:0] idx);
    clip_end = (32'(idx) < NUM_CLIPS) ? CLIP_END[idx] : 32'd0;
  endfunction

endpackage

// File: rtl/clip_prio_arb.sv
// Fixed-priority arbiter over the pending clip requests; clip 0 wins.
// Ports:
//   pending  - one bit per clip waiting to be played
//   grant_c  - combinational grant: valid, winning index, one-hot mask
//              (index reads IDLE_IDX when nothing is pending)
module clip_prio_arb
  import clip_pkg::*;
(
  input  logic [NUM_CLIPS-1:0] pending,
  output grant_t               grant_c
);

  // Scan from the lowest priority upward so the lowest index is left standing
  always_comb begin
    grant_c     = '0;
    grant_c.idx = IDLE_IDX;
    for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_c.valid     = 1'b1;
        grant_c.idx       = IDX_W'(i);
        grant_c.onehot    = '0;
        grant_c.onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clip_play_sched.sv
// Clip playback scheduler: latches per-clip play requests, picks one by fixed
// priority, walks its ROM address range and pushes one sample per TICK_DIV
// cycles to the audio controller.
// Build option: CLIP_PREEMPT_EN lets a higher-priority pending clip take over
// at the next sample boundary; without it every clip plays to its end.
// Ports:
//   CLOCK_50, resetn        - clock and asynchronous active-low reset
//   req[2:0], abort         - play request pulses, stop-and-flush
//   rom_addr, rom_q         - audio ROM (data two edges after address)
//   audio_out_allowed       - controller can take a sample
//   write_audio_out         - one-cycle write strobe
//   left_channel_audio_out  - {sample, zeros}, held between writes
//   busy, cur_clip, done    - playing, clip index (3 = idle), end-of-clip pulse
module clip_play_sched
  import clip_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2000,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned SAMP_W   = 6
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NUM_CLIPS-1:0] req,
  input  logic                 abort,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [SAMP_W-1:0]    rom_q,
  input  logic                 audio_out_allowed,
  output logic                 write_audio_out,
  output logic [31:0]          left_channel_audio_out,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_clip,
  output logic                 done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PAD_W = 32 - SAMP_W;

  state_t               state, state_d;
  logic [NUM_CLIPS-1:0] pending, pending_d, pend_c;
  logic [ADDR_W-1:0]    rom_addr_d, start_addr_c;
  logic [IDX_W-1:0]     cur_clip_d;
  logic [SAMP_W-1:0]    sample, sample_d;
  logic [31:0]          left_d;
  logic                 write_d, done_d, busy_d;
  logic [CNT_W-1:0]     cnt, cnt_d, cnt_sat_c;
  logic                 pace_ok_c, last_c, take_grant;
  grant_t               grant_c;

  // Requests of the current cycle take part in arbitration straight away
  assign pend_c = pending | req;

  clip_prio_arb u_arb (
    .pending (pend_c),
    .grant_c (grant_c)
  );

  assign start_addr_c = ADDR_W'(clip_start(grant_c.idx));
  assign last_c       = (rom_addr == ADDR_W'(clip_end(cur_clip)));
  assign cnt_sat_c    = (32'(cnt) < TICK_DIV - 32'd1) ? cnt + CNT_W'(1) : cnt;

  // PACE leaves early enough that the ADDR/WAIT/PUSH fetch lands the next
  // write exactly TICK_DIV cycles after the previous one
  assign pace_ok_c = (32'(cnt) + PIPE_LAT) >= TICK_DIV;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    pending_d  = pend_c;
    rom_addr_d = rom_addr;
    cur_clip_d = cur_clip;
    sample_d   = sample;
    left_d     = left_channel_audio_out;
    write_d    = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_sat_c;
    take_grant = 1'b0;

    case (state)
      IDLE: begin
        take_grant = grant_c.valid;
      end
      ADDR: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d  = PUSH;
        sample_d = rom_q;
      end
      PUSH: begin
        if (audio_out_allowed) begin
          write_d = 1'b1;
          left_d  = {sample, {PAD_W{1'b0}}};
          cnt_d   = '0;
          state_d = PACE;
        end
      end
      PACE: begin
        if (pace_ok_c) begin
          if (last_c) begin
            done_d = 1'b1;
            if (grant_c.valid) begin
              take_grant = 1'b1;
            end else begin
              state_d    = IDLE;
              cur_clip_d = IDLE_IDX;
            end
          end
`ifdef CLIP_PREEMPT_EN
          else if (grant_c.valid && (grant_c.idx < cur_clip)) begin
            // Preempted clip is dropped, not re-queued, and gets no done
            take_grant = 1'b1;
          end
`endif
          else begin
            rom_addr_d = rom_addr + ADDR_W'(1);
            state_d    = ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_grant) begin
      state_d    = ADDR;
      rom_addr_d = start_addr_c;
      cur_clip_d = grant_c.idx;
      pending_d  = pend_c & ~grant_c.onehot;
    end

    // abort overrides everything decided above
    if (abort) begin
      state_d    = IDLE;
      pending_d  = '0;
      cur_clip_d = IDLE_IDX;
      write_d    = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state                  <= IDLE;
      pending                <= '0;
      rom_addr               <= '0;
      cur_clip               <= IDLE_IDX;
      sample                 <= '0;
      left_channel_audio_out <= '0;
      write_audio_out        <= 1'b0;
      done                   <= 1'b0;
      busy                   <= 1'b0;
      cnt                    <= '0;
    end else begin
      state                  <= state_d;
      pending                <= pending_d;
      rom_addr               <= rom_addr_d;
      cur_clip               <= cur_clip_d;
      sample                 <= sample_d;
      left_channel_audio_out <= left_d;
      write_audio_out        <= write_d;
      done                   <= done_d;
      busy                   <= busy_d;
      cnt                    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_clip_play_sched.sv
// Self-checking bench for clip_play_sched (TICK_DIV=4, ROM data = addr[5:0]).
// Expected writes come from a queue of (clip, address) built from the clip
// tables and the priority rules; every observed write is popped and compared.
module tb_clip_play_sched;

  localparam int unsigned TICK = 4;
  localparam int          START [3] = '{0, 27101, 43831};
  localparam int          STOP  [3] = '{27100, 43830, 54300};

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic [2:0]  req     = 3'b000;
  logic        abort   = 1'b0;
  logic        allowed = 1'b1;
  logic        scramble = 1'b0;
  logic [5:0]  rom_q   = 6'd0;
  logic [15:0] rom_addr;
  logic        write_audio_out;
  logic [31:0] left;
  logic        busy;
  logic [1:0]  cur_clip;
  logic        done;

  typedef struct {
    int clip;
    int addr;
  } exp_t;

  exp_t   exp_q[$];
  int     n_chk = 0;
  int     n_bad = 0;
  int     n_wr = 0;
  int     n_done = 0;
  int     n_idle = 0;
  longint cyc = 0;
  longint last_wr = 0;
  bit     have_last = 1'b0;

  clip_play_sched #(
    .TICK_DIV (TICK),
    .ADDR_W   (16),
    .SAMP_W   (6)
  ) dut (
    .CLOCK_50               (clk),
    .resetn                 (resetn),
    .req                    (req),
    .abort                  (abort),
    .rom_addr               (rom_addr),
    .rom_q                  (rom_q),
    .audio_out_allowed      (allowed),
    .write_audio_out        (write_audio_out),
    .left_channel_audio_out (left),
    .busy                   (busy),
    .cur_clip               (cur_clip),
    .done                   (done)
  );

  always #5 clk = ~clk;

  // Behavioural ROM: one registered stage; scramble inverts the data
  always @(posedge clk) rom_q <= scramble ? ~rom_addr[5:0] : rom_addr[5:0];

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic void push_clip(input int clip, input int first, input int count);
    exp_t e;
    for (int a = first; (a < first + count) && (a <= STOP[clip]); a++) begin
      e.clip = clip;
      e.addr = a;
      exp_q.push_back(e);
    end
  endfunction

  function automatic int lowest_bit(input logic [2:0] pat);
    for (int i = 2; i >= 0; i--) if (pat[i]) lowest_bit = i;
  endfunction

  // One clock: sample on the falling edge and score any write seen
  task automatic tick();
    exp_t   e;
    logic [31:0] want_left;
    @(negedge clk);
    cyc++;
    if (!busy) n_idle++;
    if (done) n_done++;
    if (write_audio_out) begin
      n_wr++;
      check_eq("wr_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        want_left = {6'(e.addr), 26'd0};
        check_eq("wr_addr", rom_addr, e.addr);
        check_eq("wr_data", left, want_left);
        check_eq("wr_clip", cur_clip, e.clip);
      end
      if (have_last) check_eq("wr_gap", cyc - last_wr, TICK);
      last_wr   = cyc;
      have_last = 1'b1;
    end
  endtask

  task automatic wait_writes(input int target, input int bound);
    int n = 0;
    while (n_wr < target && n < bound) begin
      tick();
      n++;
    end
    if (n_wr < target) check_eq("timeout_writes", n_wr, target);
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    check_eq("timeout_queue", exp_q.size(), 0);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_clip", cur_clip, 3);
    check_eq("abort_write", write_audio_out, 0);
    check_eq("abort_done", done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=cycle %0d expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int w0, d0, i0, k, exp_done, lat;
    logic [2:0] pat;

    // Reset values
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_clip", cur_clip, 3);
    check_eq("rst_addr", rom_addr, 0);
    check_eq("rst_left", left, 0);
    check_eq("rst_write", write_audio_out, 0);
    check_eq("rst_done", done, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // Clip 2 full run with a clip 1 request arriving mid-clip
    have_last = 1'b0;
    d0 = n_done;
    w0 = n_wr;
    push_clip(2, START[2], STOP[2] - START[2] + 1);
    req = 3'b100;
    tick();
    req = 3'b000;
    i0 = n_idle;
    k = int'($urandom_range(20, 10400));
    wait_writes(w0 + k, 4 * k + 50);
    req = 3'b010;
    tick();
    req = 3'b000;
`ifdef CLIP_PREEMPT_EN
    exp_q.delete();
    exp_done = 0;
`else
    exp_done = 1;
`endif
    push_clip(1, START[1], 16);
    wait_empty(4 * 10500 + 400);
    check_eq("handoff_done", n_done - d0, exp_done);
    check_eq("handoff_no_idle", n_idle - i0, 0);
    do_abort();
    w0 = n_wr;
    d0 = n_done;
    repeat (30) tick();
    check_eq("post_abort_writes", n_wr - w0, 0);
    check_eq("post_abort_done", n_done - d0, 0);

    // Abort during clip 0 with clip 1 pending: clip 1 must be flushed
    have_last = 1'b0;
    w0 = n_wr;
    push_clip(0, START[0], 12);
    req = 3'b001;
    tick();
    req = 3'b000;
    wait_writes(w0 + 3, 40);
    req = 3'b010;
    tick();
    req = 3'b000;
    wait_writes(w0 + 6, 40);
    do_abort();
    w0 = n_wr;
    d0 = n_done;
    i0 = n_idle;
    repeat (60) tick();
    check_eq("flush_writes", n_wr - w0, 0);
    check_eq("flush_done", n_done - d0, 0);
    check_eq("flush_idle", n_idle - i0, 60);

    // Back-pressure: 50 cycles of allowed=0, ROM data corrupted while held
    have_last = 1'b0;
    w0 = n_wr;
    push_clip(2, START[2], 8);
    req = 3'b100;
    tick();
    req = 3'b000;
    wait_writes(w0 + 2, 40);
    allowed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 10) scramble = 1'b1;
    end
    check_eq("stall_writes", n_wr - w0, 2);
    check_eq("stall_busy", busy, 1);
    check_eq("stall_addr", rom_addr, START[2] + 2);
    allowed = 1'b1;
    have_last = 1'b0;
    tick();
    check_eq("stall_release", write_audio_out, 1);
    scramble = 1'b0;
    wait_empty(100);
    do_abort();

    // Asynchronous reset in the middle of clip 1
    have_last = 1'b0;
    w0 = n_wr;
    push_clip(1, START[1], 8);
    req = 3'b010;
    tick();
    req = 3'b000;
    wait_writes(w0 + 3, 40);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_clip", cur_clip, 3);
    check_eq("arst_addr", rom_addr, 0);
    check_eq("arst_left", left, 0);
    check_eq("arst_write", write_audio_out, 0);
    check_eq("arst_done", done, 0);
    exp_q.delete();
    repeat (3) tick();
    resetn = 1'b1;
    w0 = n_wr;
    d0 = n_done;
    repeat (40) tick();
    check_eq("arst_no_write", n_wr - w0, 0);
    check_eq("arst_no_done", n_done - d0, 0);
    check_eq("arst_idle_clip", cur_clip, 3);

    // Random simultaneous request patterns: lowest index wins, fixed latency
    for (int it = 0; it < 8; it++) begin
      pat = 3'($urandom_range(1, 7));
      have_last = 1'b0;
      w0 = n_wr;
      push_clip(lowest_bit(pat), START[lowest_bit(pat)], 1);
      req = pat;
      lat = 0;
      do begin
        tick();
        lat++;
        req = 3'b000;
      end while (n_wr == w0 && lat < 20);
      check_eq("first_latency", lat, 4);
      check_eq("grant_busy", busy, 1);
      do_abort();
      repeat (int'($urandom_range(1, 5))) tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
